// File: rtl/ex_mem_skid_pkg.sv
// ex_mem_skid_pkg: shared types and payload layout for the EX/MEM skid buffer.
//   state_t      : occupancy state, encoded as {skid_valid, main_valid}
//   exm_*        : payload width and field offsets, as functions of the widths.
//                  Payload layout from LSB upward: alu | store | rd | rd_we | id | pc
package ex_mem_skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_t;

  function automatic int exm_payload_w(input int dw, input int rw, input int iw);
    return 3*dw + rw + 1 + iw;
  endfunction

  function automatic int exm_off_sd(input int dw);
    return dw;
  endfunction

  function automatic int exm_off_rd(input int dw);
    return 2*dw;
  endfunction

  function automatic int exm_off_we(input int dw, input int rw);
    return 2*dw + rw;
  endfunction

  function automatic int exm_off_id(input int dw, input int rw);
    return 2*dw + rw + 1;
  endfunction

  function automatic int exm_off_pc(input int dw, input int rw, input int iw);
    return 2*dw + rw + 1 + iw;
  endfunction

endpackage

// File: rtl/ex_mem_skid_slot.sv
// ex_mem_slot: one payload register of the EX/MEM skid buffer.
//   clk, rst_n : clock, async active-low clear (payload clears to 0)
//   load       : capture d on the rising edge
//   d / q      : packed payload in / out
module ex_mem_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/ex_mem_skid.sv
// ex_mem_skid: two-entry skid buffer between execute and memory stages.
//   in_*   : valid/ready input from EX (alu result, store data, rd, rd_we, id, pc)
//   out_*  : valid/ready output toward MEM, driven straight from the main slot
//   fwd0_* : forwarding tap from the main (older) entry
//   fwd1_* : forwarding tap from the skid (younger) entry; wins on rd match
//   flush  : drops both entries and the input of that cycle
//   stall_cycles : saturating count of out_valid&!out_ready cycles, present
//                  only when EX_MEM_STALL_CNT_EN is defined
// in_ready and out_valid are plain state bits, so neither side sees a
// combinational path through the buffer.
module ex_mem_skid
  import ex_mem_skid_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int ID_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [RD_W-1:0]   in_rd_addr,
  input  logic              in_rd_we,
  input  logic [ID_W-1:0]   in_instr_id,
  input  logic [DATA_W-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [RD_W-1:0]   out_rd_addr,
  output logic              out_rd_we,
  output logic [ID_W-1:0]   out_instr_id,
  output logic [DATA_W-1:0] out_pc,
  output logic              fwd0_valid,
  output logic [RD_W-1:0]   fwd0_rd,
  output logic [DATA_W-1:0] fwd0_data,
  output logic              fwd1_valid,
  output logic [RD_W-1:0]   fwd1_rd,
  output logic [DATA_W-1:0] fwd1_data
`ifdef EX_MEM_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int PW  = exm_payload_w(DATA_W, RD_W, ID_W);
  localparam int OSD = exm_off_sd(DATA_W);
  localparam int ORD = exm_off_rd(DATA_W);
  localparam int OWE = exm_off_we(DATA_W, RD_W);
  localparam int OID = exm_off_id(DATA_W, RD_W);
  localparam int OPC = exm_off_pc(DATA_W, RD_W, ID_W);

  state_t       state;
  logic         main_valid, skid_valid;
  logic         in_fire, out_fire;
  logic         main_load, skid_load;
  logic [PW-1:0] in_pl, main_d, main_q, skid_q;

  assign main_valid = state[0];
  assign skid_valid = state[1];
  assign in_ready   = ~skid_valid;
  assign out_valid  = main_valid;

  assign in_fire  = in_valid & in_ready & ~flush;
  assign out_fire = out_valid & out_ready;

  // x0 is squashed at capture so neither the write port nor the forward
  // taps ever see it as a live destination.
  assign in_pl = {in_pc, in_instr_id, in_rd_we & (|in_rd_addr), in_rd_addr,
                  in_store_data, in_alu_result};

  // Flush suppresses every load so the data regs keep their last values.
  always_comb begin
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = in_pl;
    unique case (state)
      EMPTY: main_load = in_fire;
      ONE: begin
        main_load = in_fire & out_fire;
        skid_load = in_fire & ~out_fire;
      end
      TWO: begin
        main_load = out_fire & ~flush;
        main_d    = skid_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     state <= EMPTY;
    else if (flush) state <= EMPTY;
    else begin
      unique case (state)
        EMPTY: if (in_fire) state <= ONE;
        ONE: begin
          if (in_fire && !out_fire)      state <= TWO;
          else if (!in_fire && out_fire) state <= EMPTY;
        end
        TWO:   if (out_fire) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  ex_mem_slot #(.W(PW)) u_main (
    .clk(clk), .rst_n(rst_n), .load(main_load), .d(main_d), .q(main_q)
  );

  ex_mem_slot #(.W(PW)) u_skid (
    .clk(clk), .rst_n(rst_n), .load(skid_load), .d(in_pl), .q(skid_q)
  );

  assign out_alu_result = main_q[DATA_W-1:0];
  assign out_store_data = main_q[OSD +: DATA_W];
  assign out_rd_addr    = main_q[ORD +: RD_W];
  assign out_rd_we      = main_q[OWE];
  assign out_instr_id   = main_q[OID +: ID_W];
  assign out_pc         = main_q[OPC +: DATA_W];

  assign fwd0_valid = main_valid & main_q[OWE];
  assign fwd0_rd    = main_q[ORD +: RD_W];
  assign fwd0_data  = main_q[DATA_W-1:0];

  assign fwd1_valid = skid_valid & skid_q[OWE];
  assign fwd1_rd    = skid_q[ORD +: RD_W];
  assign fwd1_data  = skid_q[DATA_W-1:0];

`ifdef EX_MEM_STALL_CNT_EN
  // Cleared by reset only; flush leaves the count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles <= '0;
    else if (out_valid && !out_ready && stall_cycles != 32'hFFFF_FFFF)
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
module tb_ex_mem_skid;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, in_rd_we, out_valid, out_ready;
  logic [31:0] in_alu_result, in_store_data, in_pc;
  logic [4:0]  in_rd_addr;
  logic [5:0]  in_instr_id;
  logic [31:0] out_alu_result, out_store_data, out_pc;
  logic [4:0]  out_rd_addr;
  logic        out_rd_we;
  logic [5:0]  out_instr_id;
  logic        fwd0_valid, fwd1_valid;
  logic [4:0]  fwd0_rd, fwd1_rd;
  logic [31:0] fwd0_data, fwd1_data;
`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] stall_exp = 0;
`endif

  always #5 clk = ~clk;

  ex_mem_skid dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_store_data(in_store_data),
    .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we), .in_instr_id(in_instr_id), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_result(out_alu_result), .out_store_data(out_store_data),
    .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we), .out_instr_id(out_instr_id), .out_pc(out_pc),
    .fwd0_valid(fwd0_valid), .fwd0_rd(fwd0_rd), .fwd0_data(fwd0_data),
    .fwd1_valid(fwd1_valid), .fwd1_rd(fwd1_rd), .fwd1_data(fwd1_data)
`ifdef EX_MEM_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  typedef struct {
    logic [31:0] alu, sd, pc;
    logic [4:0]  rd;
    logic        we;
    logic [5:0]  id;
  } ent_t;

  ent_t q[$];      // entries held by the buffer, oldest first
  int   occ = 0;   // occupancy at the start of the current cycle
  int   checks = 0, errors = 0;
  int   outs_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the expected entry is queued when the model says it is accepted.
  task automatic drive(input logic v, input logic rdy, input logic fl,
                       input logic [31:0] alu, input logic [4:0] rd, input logic we);
    ent_t e;
    @(posedge clk); #1;
    occ           = q.size();
    in_valid      = v;
    out_ready     = rdy;
    flush         = fl;
    in_alu_result = alu;
    in_store_data = $urandom;
    in_pc         = $urandom;
    in_rd_addr    = rd;
    in_rd_we      = we;
    in_instr_id   = 6'($urandom);
    if (v && occ < 2 && !fl) begin
      e.alu = alu; e.sd = in_store_data; e.pc = in_pc;
      e.rd = rd; e.we = we && (rd != 0); e.id = in_instr_id;
      q.push_back(e);
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 1'b0);
  endtask

  // Monitor: mid-cycle, compare DUT against the model, then retire/flush model entries.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, (occ < 2) ? 1 : 0);
      chk("out_valid", out_valid, (occ > 0) ? 1 : 0);
      if (occ > 0) begin
        chk("out_alu", out_alu_result, q[0].alu);
        chk("out_sd", out_store_data, q[0].sd);
        chk("out_pc", out_pc, q[0].pc);
        chk("out_rd", 32'(out_rd_addr), 32'(q[0].rd));
        chk("out_we", 32'(out_rd_we), 32'(q[0].we));
        chk("out_id", 32'(out_instr_id), 32'(q[0].id));
        chk("fwd0_valid", 32'(fwd0_valid), 32'(q[0].we));
        if (q[0].we) begin
          chk("fwd0_rd", 32'(fwd0_rd), 32'(q[0].rd));
          chk("fwd0_data", fwd0_data, q[0].alu);
        end
      end else chk("fwd0_valid_empty", 32'(fwd0_valid), 0);
      if (occ == 2) begin
        chk("fwd1_valid", 32'(fwd1_valid), 32'(q[1].we));
        if (q[1].we) begin
          chk("fwd1_rd", 32'(fwd1_rd), 32'(q[1].rd));
          chk("fwd1_data", fwd1_data, q[1].alu);
        end
      end else chk("fwd1_valid_idle", 32'(fwd1_valid), 0);
`ifdef EX_MEM_STALL_CNT_EN
      chk("stall_cycles", stall_cycles, stall_exp);
      if (occ > 0 && !out_ready) stall_exp++;
`endif
      if (occ > 0 && out_ready) begin
        void'(q.pop_front());
        outs_seen++;
      end
      if (flush) q.delete();
    end
  end

  initial begin
    logic [31:0] sel;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_alu_result = '0; in_store_data = '0; in_pc = '0;
    in_rd_addr = '0; in_rd_we = 1'b0; in_instr_id = '0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_alu", out_alu_result, 0);
    chk("rst_fwd", {fwd0_valid, fwd1_valid, fwd0_rd, fwd1_rd}, 0);
    rst_n = 1'b1;

    // 1: stream of 8 ADDI results, sink always ready
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 32'h100 + i, 5'(i + 1), 1'b1);
    idle(); idle();
    chk("stream_outputs", outs_seen, 8);

    // 2: sink stalls 3 cycles with input valid, then releases
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 32'h200 + i, 5'd3, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 0, 0, 0);
    idle(); idle();

    // 3: flush while full with input valid
    drive(1'b1, 1'b0, 1'b0, 32'h300, 5'd7, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h301, 5'd8, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 32'h302, 5'd9, 1'b1);
    idle(); idle();

    // 4: x0 destination is never forwarded
    drive(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 5'd0, 1'b1);
    idle();

    // 5: same rd in both entries; the younger one must win
    drive(1'b1, 1'b0, 1'b0, 32'h22, 5'd5, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
    drive(1'b1, 1'b0, 1'b0, 32'h11, 5'd5, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
    sel = (fwd1_valid && fwd1_rd == 5'd5) ? fwd1_data :
          (fwd0_valid && fwd0_rd == 5'd5) ? fwd0_data : 32'h0;
    chk("fwd_select_younger", sel, 32'h11);
    idle(); idle();

    // 6b: ten stall cycles then a flush; counter must keep its value
    drive(1'b1, 1'b0, 1'b0, 32'h600, 5'd6, 1'b1);
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b1, 0, 0, 0);
    idle(); idle();

    // random traffic
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 19) == 0), $urandom, 5'($urandom), 1'($urandom));

    // 6: async reset while full
    drive(1'b1, 1'b0, 1'b0, 32'h700, 5'd1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h701, 5'd2, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_out_alu", out_alu_result, 0);
    chk("arst_out_pc", out_pc, 0);
    chk("arst_fwd", {fwd0_valid, fwd1_valid, fwd0_rd, fwd1_rd}, 0);
    chk("arst_fwd_data", fwd0_data | fwd1_data, 0);
    q.delete();
    @(posedge clk); #1;
    occ = 0;
`ifdef EX_MEM_STALL_CNT_EN
    chk("arst_stall_cycles", stall_cycles, 0);
    stall_exp = 0;
`endif
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 32'h800 + i, 5'd4, 1'b1);
    idle(); idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
